// File: rtl/vend_ctrl_multi_pkg.sv
// Shared definitions for the multi-product vending controller:
// FSM state encoding, coin values in nickel units and a width helper.
package vend_ctrl_multi_pkg;

  typedef enum logic [2:0] {
    ST_ACCEPT = 3'd0,
    ST_READY  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } vend_state_e;

  localparam int unsigned COIN_N_UNITS = 1;
  localparam int unsigned COIN_D_UNITS = 2;
  localparam int unsigned COIN_Q_UNITS = 5;

  // Index width for a product id; a single product still needs one bit.
  function automatic int unsigned idWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Customer/operator bus of the vending controller.
// The slave modport is the controller side, the master modport the driver side.
interface vend_ctrl_multi_if #(
  parameter int NUM_PROD    = 2,
  parameter int PRICE_UNITS = 9
);
  import vend_ctrl_multi_pkg::*;

  localparam int CW  = $clog2(PRICE_UNITS + 5 + 1);
  localparam int IDW = idWidth(NUM_PROD);

  logic                i_coin_n;
  logic                i_coin_d;
  logic                i_coin_q;
  logic [NUM_PROD-1:0] i_sel;
  logic                i_cancel;
  logic                i_restock;
  logic [IDW-1:0]      i_restock_id;
  logic                o_accepting;
  logic [CW-1:0]       o_credit;
  logic [NUM_PROD-1:0] o_dispense;
  logic                o_change;
  logic                o_coin_reject;
  logic [NUM_PROD-1:0] o_sold_out;
  logic                o_busy;

  modport slave (
    input  i_coin_n, i_coin_d, i_coin_q, i_sel, i_cancel, i_restock, i_restock_id,
    output o_accepting, o_credit, o_dispense, o_change, o_coin_reject, o_sold_out, o_busy
  );

  modport master (
    output i_coin_n, i_coin_d, i_coin_q, i_sel, i_cancel, i_restock, i_restock_id,
    input  o_accepting, o_credit, o_dispense, o_change, o_coin_reject, o_sold_out, o_busy
  );

endinterface

// File: rtl/vend_ctrl_multi_timer.sv
// Loadable down-counter shared by the dispense interval and change half-periods.
// o_done is high during the last counted cycle, so a load of N spans exactly N cycles.
module vend_timer #(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_done
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_done = (r_count == TW'(1));

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending controller: NUM_PROD products at one price with per-product stock,
// nickel-unit credit, timed dispense and change returned as nickel pulses.
module vend_ctrl_multi
  import vend_ctrl_multi_pkg::*;
#(
  parameter int NUM_PROD    = 2,
  parameter int PRICE_UNITS = 9,
  parameter int STOCK_MAX   = 15,
  parameter int DISP_CYCLES = 250000000,
  parameter int CHG_CYCLES  = 250000000
) (
  input  logic             clk,
  input  logic             rst_n,
  vend_ctrl_multi_if.slave bus
);

  localparam int CW   = $clog2(PRICE_UNITS + 5 + 1);
  localparam int SW   = $clog2(STOCK_MAX + 1);
  localparam int IDW  = idWidth(NUM_PROD);
  localparam int TMAX = (DISP_CYCLES > CHG_CYCLES) ? DISP_CYCLES : CHG_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  vend_state_e         r_state;
  logic [CW-1:0]       r_credit;
  logic [SW-1:0]       r_stock [NUM_PROD];
  logic [NUM_PROD-1:0] r_dispense;
  logic                r_change;
  logic                r_coin_reject;

  logic                w_coin_any;
  logic                w_coin_multi;
  logic [CW-1:0]       w_coin_units;
  logic [CW-1:0]       w_credit_sum;
  logic                w_cancel_ok;
  logic                w_sel_hit;
  logic [IDW-1:0]      w_sel_idx;
  logic                w_start_vend;
  logic                w_start_pay;
  logic                w_pay_next;
  logic                w_timer_load;
  logic [TW-1:0]       w_timer_val;
  logic                w_timer_done;
  logic [NUM_PROD-1:0] w_sold_out;

  assign w_coin_any   = bus.i_coin_n | bus.i_coin_d | bus.i_coin_q;
  assign w_coin_multi = (bus.i_coin_n & bus.i_coin_d) | (bus.i_coin_n & bus.i_coin_q) |
                        (bus.i_coin_d & bus.i_coin_q);
  assign w_coin_units = bus.i_coin_q ? CW'(COIN_Q_UNITS) :
                        bus.i_coin_d ? CW'(COIN_D_UNITS) :
                        bus.i_coin_n ? CW'(COIN_N_UNITS) : '0;
  assign w_credit_sum = r_credit + w_coin_units;
  assign w_cancel_ok  = bus.i_cancel && (r_credit != '0) &&
                        ((r_state == ST_ACCEPT) || (r_state == ST_READY));

  // Lowest-index selected product that still has stock.
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_idx = '0;
    for (int i = NUM_PROD - 1; i >= 0; i--) begin
      if (bus.i_sel[i] && (r_stock[i] != '0)) begin
        w_sel_hit = 1'b1;
        w_sel_idx = IDW'(i);
      end
    end
  end

  assign w_start_vend = (r_state == ST_READY) && !w_cancel_ok && w_sel_hit;
  assign w_start_pay  = w_cancel_ok ||
                        ((r_state == ST_VEND) && w_timer_done && (r_credit != '0));
  assign w_pay_next   = ((r_state == ST_CHANGE) || (r_state == ST_REFUND)) && w_timer_done &&
                        (r_change || (r_credit != '0));
  assign w_timer_load = w_start_vend | w_start_pay | w_pay_next;
  assign w_timer_val  = w_start_vend ? TW'(DISP_CYCLES) : TW'(CHG_CYCLES);

  vend_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ACCEPT;
      r_credit      <= '0;
      r_dispense    <= '0;
      r_change      <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= w_coin_any && ((r_state != ST_ACCEPT) || w_cancel_ok || w_coin_multi);
      case (r_state)
        ST_ACCEPT: begin
          if (w_cancel_ok) begin
            r_state  <= ST_REFUND;
            r_change <= 1'b1;
          end else if (w_coin_any) begin
            r_credit <= w_credit_sum;
            if (w_credit_sum >= CW'(PRICE_UNITS)) r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_cancel_ok) begin
            r_state  <= ST_REFUND;
            r_change <= 1'b1;
          end else if (w_start_vend) begin
            r_state    <= ST_VEND;
            r_dispense <= NUM_PROD'(1) << w_sel_idx;
            r_credit   <= r_credit - CW'(PRICE_UNITS);
          end
        end
        ST_VEND: begin
          if (w_timer_done) begin
            r_dispense <= '0;
            if (r_credit != '0) begin
              r_state  <= ST_CHANGE;
              r_change <= 1'b1;
            end else begin
              r_state <= ST_ACCEPT;
            end
          end
        end
        ST_CHANGE, ST_REFUND: begin
          // A nickel is counted as paid when its high phase ends.
          if (w_timer_done) begin
            if (r_change) begin
              r_change <= 1'b0;
              r_credit <= r_credit - CW'(1);
            end else if (r_credit == '0) begin
              r_state <= ST_ACCEPT;
            end else begin
              r_change <= 1'b1;
            end
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  // Restock wins over a same-cycle vend of the same product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= SW'(STOCK_MAX);
    end else begin
      for (int i = 0; i < NUM_PROD; i++) begin
        if (bus.i_restock && (bus.i_restock_id == IDW'(i))) begin
          r_stock[i] <= SW'(STOCK_MAX);
        end else if (w_start_vend && (w_sel_idx == IDW'(i))) begin
          r_stock[i] <= r_stock[i] - SW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PROD; g++) begin : g_sold_out
    assign w_sold_out[g] = (r_stock[g] == '0);
  end

  assign bus.o_accepting   = (r_state == ST_ACCEPT);
  assign bus.o_busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE) ||
                             (r_state == ST_REFUND);
  assign bus.o_credit      = r_credit;
  assign bus.o_dispense    = r_dispense;
  assign bus.o_change      = r_change;
  assign bus.o_coin_reject = r_coin_reject;
  assign bus.o_sold_out    = w_sold_out;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of credit, stock and payout timing.
module tb_vend_ctrl_multi;

  localparam int NUM_PROD    = 2;
  localparam int PRICE_UNITS = 9;
  localparam int STOCK_MAX   = 2;
  localparam int DISP_CYCLES = 4;
  localparam int CHG_CYCLES  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   checkEn;

  vend_ctrl_multi_if #(.NUM_PROD(NUM_PROD), .PRICE_UNITS(PRICE_UNITS)) bus ();

  vend_ctrl_multi #(
    .NUM_PROD    (NUM_PROD),
    .PRICE_UNITS (PRICE_UNITS),
    .STOCK_MAX   (STOCK_MAX),
    .DISP_CYCLES (DISP_CYCLES),
    .CHG_CYCLES  (CHG_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: idle (mode 0), vending (1) or paying out (2); mAge counts cycles in the activity.
  int mMode;
  int mCredit;
  int mAge;
  int mEntry;
  int mProd;
  int mStock [NUM_PROD];
  bit mReject;

  task automatic modelReset();
    mMode   = 0;
    mCredit = 0;
    mAge    = 0;
    mEntry  = 0;
    mProd   = 0;
    for (int i = 0; i < NUM_PROD; i++) mStock[i] = STOCK_MAX;
    mReject = 0;
  endtask

  task automatic modelStep(input bit n, input bit d, input bit q, input bit [NUM_PROD-1:0] sel,
                           input bit cancel, input bit restock, input int id);
    int coins;
    bit rej;
    bit found;
    coins = int'(n) + int'(d) + int'(q);
    rej   = 0;
    found = 0;
    if (mMode == 0) begin
      if (cancel && mCredit > 0) begin
        mMode  = 2;
        mEntry = mCredit;
        mAge   = 0;
        rej    = coins > 0;
      end else if (mCredit < PRICE_UNITS) begin
        if (coins > 0) begin
          mCredit += q ? 5 : (d ? 2 : 1);
          rej = coins > 1;
        end
      end else begin
        rej = coins > 0;
        for (int i = 0; i < NUM_PROD; i++) begin
          if (!found && sel[i] && mStock[i] > 0) begin
            found     = 1;
            mStock[i] = mStock[i] - 1;
            mCredit   = mCredit - PRICE_UNITS;
            mMode     = 1;
            mAge      = 0;
            mProd     = i;
          end
        end
      end
    end else if (mMode == 1) begin
      rej = coins > 0;
      mAge++;
      if (mAge == DISP_CYCLES) begin
        if (mCredit > 0) begin
          mMode  = 2;
          mEntry = mCredit;
          mAge   = 0;
        end else begin
          mMode = 0;
        end
      end
    end else begin
      rej = coins > 0;
      mAge++;
      if (mAge == 2 * CHG_CYCLES * mEntry) begin
        mMode   = 0;
        mCredit = 0;
      end
    end
    if (restock && id < NUM_PROD) mStock[id] = STOCK_MAX;
    mReject = rej;
  endtask

  function automatic int expCredit();
    if (mMode == 2) return mEntry - (mAge + CHG_CYCLES) / (2 * CHG_CYCLES);
    return mCredit;
  endfunction

  function automatic int expDispense();
    return (mMode == 1) ? (1 << mProd) : 0;
  endfunction

  function automatic int expChange();
    return (mMode == 2 && ((mAge / CHG_CYCLES) % 2 == 0)) ? 1 : 0;
  endfunction

  function automatic int expSoldOut();
    int v;
    v = 0;
    for (int i = 0; i < NUM_PROD; i++) if (mStock[i] == 0) v |= (1 << i);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("credit", int'(bus.o_credit), expCredit());
      checkOutput("dispense", int'(bus.o_dispense), expDispense());
      checkOutput("change", int'(bus.o_change), expChange());
      checkOutput("coin_reject", int'(bus.o_coin_reject), int'(mReject));
      checkOutput("accepting", int'(bus.o_accepting), (mMode == 0 && mCredit < PRICE_UNITS) ? 1 : 0);
      checkOutput("busy", int'(bus.o_busy), (mMode != 0) ? 1 : 0);
      checkOutput("sold_out", int'(bus.o_sold_out), expSoldOut());
    end
  end

  // Observed dispense-high cycles and change pulses, for the literal scenario checks.
  int dispCycles;
  int changePulses;
  bit prevChange;

  always @(negedge clk) begin
    if (rst_n) begin
      if (|bus.o_dispense) dispCycles <= dispCycles + 1;
      if (bus.o_change && !prevChange) changePulses <= changePulses + 1;
      prevChange <= bus.o_change;
    end else begin
      prevChange <= 1'b0;
    end
  end

  task automatic applyStimulus(input bit n, input bit d, input bit q, input bit [NUM_PROD-1:0] sel,
                               input bit cancel, input bit restock, input bit id);
    bus.i_coin_n     = n;
    bus.i_coin_d     = d;
    bus.i_coin_q     = q;
    bus.i_sel        = sel;
    bus.i_cancel     = cancel;
    bus.i_restock    = restock;
    bus.i_restock_id = id;
    @(posedge clk);
    modelStep(n, d, q, sel, cancel, restock, int'(id));
    @(negedge clk);
    bus.i_coin_n     = 0;
    bus.i_coin_d     = 0;
    bus.i_coin_q     = 0;
    bus.i_sel        = '0;
    bus.i_cancel     = 0;
    bus.i_restock    = 0;
    bus.i_restock_id = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic coinN(); applyStimulus(1, 0, 0, 2'b00, 0, 0, 0); endtask
  task automatic coinD(); applyStimulus(0, 1, 0, 2'b00, 0, 0, 0); endtask
  task automatic coinQ(); applyStimulus(0, 0, 1, 2'b00, 0, 0, 0); endtask

  int d0;
  int p0;

  initial begin
    checks  = 0;
    errors  = 0;
    checkEn = 0;
    dispCycles   = 0;
    changePulses = 0;
    prevChange   = 0;
    rst_n = 0;
    bus.i_coin_n = 0; bus.i_coin_d = 0; bus.i_coin_q = 0;
    bus.i_sel = '0; bus.i_cancel = 0; bus.i_restock = 0; bus.i_restock_id = 0;
    modelReset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    #1;
    checkOutput("reset credit", int'(bus.o_credit), 0);
    checkOutput("reset accepting", int'(bus.o_accepting), 1);
    checkOutput("reset busy", int'(bus.o_busy), 0);
    checkOutput("reset sold_out", int'(bus.o_sold_out), 0);
    checkOutput("reset dispense", int'(bus.o_dispense), 0);
    checkOutput("reset change", int'(bus.o_change), 0);
    checkEn = 1;
    @(negedge clk);

    $display("[TB] exact price, product 0");
    coinQ(); coinD(); coinD();
    #1 checkOutput("s1 credit", int'(bus.o_credit), 9);
    checkOutput("s1 accepting", int'(bus.o_accepting), 0);
    d0 = dispCycles; p0 = changePulses;
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    idle(6);
    #1 checkOutput("s1 dispense cycles", dispCycles - d0, 4);
    checkOutput("s1 change pulses", changePulses - p0, 0);

    $display("[TB] overpay, product 1 with change");
    coinQ(); coinD(); coinN();
    #1 checkOutput("s2 credit 8", int'(bus.o_credit), 8);
    coinQ();
    #1 checkOutput("s2 credit 13", int'(bus.o_credit), 13);
    d0 = dispCycles; p0 = changePulses;
    applyStimulus(0, 0, 0, 2'b10, 0, 0, 0);
    idle(22);
    #1 checkOutput("s2 dispense cycles", dispCycles - d0, 4);
    checkOutput("s2 change pulses", changePulses - p0, 4);
    checkOutput("s2 accepting", int'(bus.o_accepting), 1);

    $display("[TB] cancel refund");
    coinD(); coinN();
    d0 = dispCycles; p0 = changePulses;
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 0);
    idle(14);
    #1 checkOutput("s3 change pulses", changePulses - p0, 3);
    checkOutput("s3 dispense cycles", dispCycles - d0, 0);
    checkOutput("s3 credit", int'(bus.o_credit), 0);
    checkOutput("s3 accepting", int'(bus.o_accepting), 1);

    $display("[TB] simultaneous coins and coin in ready");
    applyStimulus(1, 0, 1, 2'b00, 0, 0, 0);
    #1 checkOutput("s4 credit", int'(bus.o_credit), 5);
    checkOutput("s4 reject", int'(bus.o_coin_reject), 1);
    coinD(); coinD();
    coinN();
    #1 checkOutput("s4 ready credit", int'(bus.o_credit), 9);
    checkOutput("s4 ready reject", int'(bus.o_coin_reject), 1);
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    idle(6);
    #1 checkOutput("s4 sold_out", int'(bus.o_sold_out), 1);

    $display("[TB] sold out, restock");
    coinQ(); coinD(); coinD();
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    idle(2);
    #1 checkOutput("s5 busy", int'(bus.o_busy), 0);
    checkOutput("s5 credit", int'(bus.o_credit), 9);
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
    #1 checkOutput("s5 sold_out", int'(bus.o_sold_out), 0);
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    idle(6);

    $display("[TB] reset during dispense");
    coinN(); coinQ(); coinD(); coinD();
    applyStimulus(0, 0, 0, 2'b10, 0, 0, 0);
    idle(1);
    #2 rst_n = 0;
    #1 checkOutput("s6 dispense", int'(bus.o_dispense), 0);
    checkOutput("s6 credit", int'(bus.o_credit), 0);
    checkOutput("s6 accepting", int'(bus.o_accepting), 1);
    modelReset();
    @(negedge clk);
    #2 rst_n = 1;
    d0 = dispCycles;
    coinQ(); coinD(); coinD();
    applyStimulus(0, 0, 0, 2'b01, 0, 0, 0);
    idle(6);
    #1 checkOutput("s6 resume dispense cycles", dispCycles - d0, 4);

    $display("[TB] random traffic");
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                    $urandom_range(0, 7) == 0,
                    {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
                    $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                    1'($urandom_range(0, 1)));
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
